mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit between the EX/MEM pipeline register and the 64x32 word-addressed synchronous-write data memory.
- Converts byte addresses plus access size into word accesses on the memory port. Extracts and sign/zero-extends sub-word load data.
- Implements sb/sh as a two-cycle read-modify-write, stalling upstream for one cycle.
- Flags misaligned or illegal accesses and suppresses them.

Parameters:
- ADDR_W, 6, word-address width of the data memory (depth 2**ADDR_W words). Byte address bits [ADDR_W+1:2] select the word; higher bits are ignored (wrap).

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  synchronous active-high reset
- op_valid  input  1  memory operation present this cycle
- op_write  input  1  1 = store, 0 = load
- op_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- op_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- op_addr  input  32  byte address
- op_wdata  input  32  store data; sub-word stores use low bits
- ld_data  output  32  extended load result; combinational, same cycle
- stall  output  1  hold upstream pipeline this cycle
- fault  output  1  misaligned or illegal-size access; combinational
- mem_addr  output  ADDR_W  word address to data memory
- mem_wd  output  32  write data to data memory
- mem_memwrite  output  1  memory write enable; write lands at next posedge
- mem_memread  output  1  memory read enable
- mem_rd  input  32  combinational read data from memory

Behaviour:
- Byte order is big-endian.
  - Byte offset 0 = bits[31:24], offset 3 = bits[7:0].
  - Half offset 0 = bits[31:16], offset 2 = bits[15:0].
- fault = op_valid & (size==11 | (half & addr[0]) | (word & addr[1:0]!=0)), evaluated in IDLE only.
  - A faulting op issues no memread/memwrite, no stall; ld_data = 0.
- FSM states: IDLE and RMW_WR; register rmw_word[31:0], rmw_addr[ADDR_W-1:0].
- IDLE, no op or fault: memread = 0, memwrite = 0, stall = 0, ld_data = 0.
- IDLE, load: memread = 1, mem_addr = word index; ld_data = extracted/extended field of mem_rd in the same cycle; stall = 0; stay in IDLE.
- IDLE, sw: memwrite = 1, mem_wd = op_wdata; single cycle; stall = 0; stay in IDLE.
- IDLE, sb/sh:
  - memread = 1, memwrite = 0, stall = 1.
  - Merge op_wdata low byte/half into mem_rd at the offset.
  - Latch the merged word into rmw_word and the word index into rmw_addr; go to RMW_WR.
- RMW_WR:
  - memwrite = 1, mem_addr = rmw_addr, mem_wd = rmw_word, memread = 0, stall = 0.
  - The op_* inputs (still the held store) are ignored; fault = 0; ld_data = 0.
  - Always return to IDLE next cycle. The pipeline advances at the end of this cycle.
- Store latency:
  - sw is committed at the 1st posedge.
  - sb/sh is committed at the 2nd posedge; the memory holds the new word from then on.
- Read-after-write: a load in the cycle after a store commit sees the new data (memory updated at posedge, read is combinational).
- Reset, synchronous: state ← IDLE, rmw_word ← 0, rmw_addr ← 0.
  - While rst = 1, all outputs are forced to 0 (stall, fault, memwrite, memread, ld_data, mem_wd, mem_addr).
  - Reset during RMW_WR aborts the write: no memory update.
- The unit has no memory of its own and never writes during a fault or reset.

Test Plan:
- Memory preloaded with word i = i. Load lw addr 0x14 -> memread = 1, mem_addr = 5, ld_data = 0x00000005, stall = 0, fault = 0.
- sb wdata = 0x000000AB at addr 0x14 -> cycle 1: stall = 1, memwrite = 0. Cycle 2: memwrite = 1, mem_wd = 0xAB000005, stall = 0. Then lb 0x14 -> ld_data = 0xFFFFFFAB; lbu 0x14 -> 0x000000AB.
- sh wdata = 0x00001234 at 0x16 after the above -> word 5 = 0xAB001234. lh 0x16 -> 0x00001234; lh 0x14 -> 0xFFFFAB00; lhu 0x14 -> 0x0000AB00.
- Misaligned and illegal ops:
  - lh at 0x15 -> fault = 1, memread = 0, ld_data = 0.
  - sw at 0x22 -> fault = 1, memwrite = 0; word 8 remains 0x00000008.
  - op_size = 11 -> fault = 1.
- Reset mid-RMW: sb 0xCC at 0x20, then assert rst in the RMW_WR cycle -> memwrite = 0, word 8 unchanged (0x00000008), state IDLE after reset.
- Back-to-back: sw 0xDEADBEEF at 0x04, then lw 0x04 next cycle -> ld_data = 0xDEADBEEF, no stall. Address 0x104 aliases word 1 (wrap).

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte-addressed big-endian loads/stores onto a
// word-addressed synchronous-write data memory, with read-modify-write for sb/sh.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              op_write,
    input  logic [1:0]        op_size,
    input  logic              op_unsigned,
    input  logic [31:0]       op_addr,
    input  logic [31:0]       op_wdata,
    output logic [31:0]       ld_data,
    output logic              stall,
    output logic              fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              mem_memwrite,
    output logic              mem_memread,
    input  logic [31:0]       mem_rd
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_RMW_WR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       rmw_word_q, rmw_word_d;
    logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_off;
    logic              bad_op;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       ld_ext;
    logic [31:0]       merged;
    logic              unused_addr_hi;

    // Address bits above the memory depth wrap and are intentionally ignored.
    assign unused_addr_hi = ^op_addr[31:ADDR_W+2];
    assign word_idx       = op_addr[ADDR_W+1:2];
    assign byte_off       = op_addr[1:0];

    assign bad_op = (op_size == 2'b11)
                  | ((op_size == SZ_HALF) & op_addr[0])
                  | ((op_size == SZ_WORD) & (byte_off != 2'b00));

    // Big-endian field select and extension of load data.
    always_comb begin
        rd_byte = 8'h00;
        rd_half = byte_off[1] ? mem_rd[15:0] : mem_rd[31:16];
        case (byte_off)
            2'd0:    rd_byte = mem_rd[31:24];
            2'd1:    rd_byte = mem_rd[23:16];
            2'd2:    rd_byte = mem_rd[15:8];
            default: rd_byte = mem_rd[7:0];
        endcase
        case (op_size)
            SZ_BYTE: ld_ext = {{24{~op_unsigned & rd_byte[7]}}, rd_byte};
            SZ_HALF: ld_ext = {{16{~op_unsigned & rd_half[15]}}, rd_half};
            default: ld_ext = mem_rd;
        endcase
    end

    // Insert the store's low byte/half into the word read this cycle.
    always_comb begin
        merged = mem_rd;
        if (op_size == SZ_BYTE) begin
            case (byte_off)
                2'd0:    merged[31:24] = op_wdata[7:0];
                2'd1:    merged[23:16] = op_wdata[7:0];
                2'd2:    merged[15:8]  = op_wdata[7:0];
                default: merged[7:0]   = op_wdata[7:0];
            endcase
        end else if (byte_off[1]) begin
            merged[15:0] = op_wdata[15:0];
        end else begin
            merged[31:16] = op_wdata[15:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        rmw_word_d   = rmw_word_q;
        rmw_addr_d   = rmw_addr_q;
        ld_data      = 32'h0;
        stall        = 1'b0;
        fault        = 1'b0;
        mem_addr     = '0;
        mem_wd       = 32'h0;
        mem_memwrite = 1'b0;
        mem_memread  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        if (bad_op) begin
                            fault = 1'b1;
                        end else if (!op_write) begin
                            mem_memread = 1'b1;
                            mem_addr    = word_idx;
                            ld_data     = ld_ext;
                        end else if (op_size == SZ_WORD) begin
                            mem_memwrite = 1'b1;
                            mem_addr     = word_idx;
                            mem_wd       = op_wdata;
                        end else begin
                            mem_memread = 1'b1;
                            mem_addr    = word_idx;
                            stall       = 1'b1;
                            rmw_word_d  = merged;
                            rmw_addr_d  = word_idx;
                            state_d     = S_RMW_WR;
                        end
                    end
                end
                S_RMW_WR: begin
                    mem_memwrite = 1'b1;
                    mem_addr     = rmw_addr_q;
                    mem_wd       = rmw_word_q;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rmw_word_q <= 32'h0;
            rmw_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rmw_word_q <= rmw_word_d;
            rmw_addr_q <= rmw_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset corner cases and
// random ops checked against an arithmetic big-endian memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_write;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [31:0] ld_data;
    logic        stall;
    logic        fault;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wd;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_rd;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        preload;
    logic [31:0] last_ld;
    logic        last_fault;

    mem_access_unit #(.ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_write(op_write),
        .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr),
        .op_wdata(op_wdata), .ld_data(ld_data), .stall(stall), .fault(fault),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_memwrite(mem_memwrite),
        .mem_memread(mem_memread), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write at posedge.
    assign mem_rd = mem[mem_addr];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
        end else if (mem_memwrite) begin
            mem[mem_addr] <= mem_wd;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        logic [31:0] w;
        logic [31:0] v;
        int sh;
        w = ref_mem[a[7:2]];
        if (sz == 2'd0) begin
            sh = 8 * (3 - int'(a[1:0]));
            v = (w >> sh) & 32'hFF;
            if (!u && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            sh = 8 * (2 - int'(a[1:0]));
            v = (w >> sh) & 32'hFFFF;
            if (!u && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        logic [31:0] m;
        int sh;
        w = ref_mem[a[7:2]];
        if (sz == 2'd2) return d;
        if (sz == 2'd0) begin
            sh = 8 * (3 - int'(a[1:0]));
            m = 32'hFF << sh;
        end else begin
            sh = 8 * (2 - int'(a[1:0]));
            m = 32'hFFFF << sh;
        end
        return (w & ~m) | ((d << sh) & m);
    endfunction

    task automatic do_op(input logic wr, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        logic       flt;
        logic       sub;
        logic [5:0] idx;
        idx = a[7:2];
        flt = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        sub = wr && !flt && sz != 2'd2;
        @(negedge clk);
        op_valid = 1'b1; op_write = wr; op_size = sz; op_unsigned = u;
        op_addr = a; op_wdata = wd;
        #1;
        chk("fault", 32'(fault), 32'(flt));
        chk("stall", 32'(stall), 32'(sub));
        chk("memread", 32'(mem_memread), 32'(!flt && (!wr || sub)));
        chk("memwrite", 32'(mem_memwrite), 32'(wr && !flt && sz == 2'd2));
        chk("ld_data", ld_data, (!wr && !flt) ? ref_load(a, sz, u) : 32'h0);
        if (!flt) chk("mem_addr", 32'(mem_addr), 32'(idx));
        if (wr && !flt && sz == 2'd2) chk("mem_wd", mem_wd, wd);
        last_ld = ld_data;
        last_fault = fault;
        if (wr && !flt) ref_mem[idx] = ref_store(a, sz, wd);
        if (sub) begin
            @(negedge clk);
            #1;
            chk("rmw_memwrite", 32'(mem_memwrite), 32'h1);
            chk("rmw_stall", 32'(stall), 32'h0);
            chk("rmw_memread", 32'(mem_memread), 32'h0);
            chk("rmw_fault", 32'(fault), 32'h0);
            chk("rmw_ld", ld_data, 32'h0);
            chk("rmw_addr", 32'(mem_addr), 32'(idx));
            chk("rmw_wd", mem_wd, ref_mem[idx]);
        end
        @(posedge clk);
        #1;
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_fault;
        logic [31:0] exp_ld;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0,        1'b0, 32'h00000005};
        tbl[1]  = '{1'b1, 2'd0, 1'b0, 32'h14,  32'h000000AB, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h14,  32'h0,        1'b0, 32'hFFFFFFAB};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h14,  32'h0,        1'b0, 32'h000000AB};
        tbl[4]  = '{1'b1, 2'd1, 1'b0, 32'h16,  32'h00001234, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h16,  32'h0,        1'b0, 32'h00001234};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h14,  32'h0,        1'b0, 32'hFFFFAB00};
        tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h14,  32'h0,        1'b0, 32'h0000AB00};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0,        1'b0, 32'hAB001234};
        tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'h15,  32'h0,        1'b1, 32'h0};
        tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h22,  32'h12345678, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        1'b0, 32'h00000008};
        tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h00,  32'h0,        1'b1, 32'h0};
        tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h04,  32'hDEADBEEF, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h04,  32'h0,        1'b0, 32'hDEADBEEF};
        tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        1'b0, 32'hDEADBEEF};

        for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i);

        // Reset with an op presented: every output must be held at zero.
        rst = 1'b1; preload = 1'b1;
        op_valid = 1'b1; op_write = 1'b1; op_size = 2'd0; op_unsigned = 1'b0;
        op_addr = 32'h14; op_wdata = 32'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_memwrite", 32'(mem_memwrite), 32'h0);
        chk("rst_memread", 32'(mem_memread), 32'h0);
        chk("rst_ld", ld_data, 32'h0);
        chk("rst_wd", mem_wd, 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        rst = 1'b0; preload = 1'b0; op_valid = 1'b0;

        for (int i = 0; i < 16; i++) begin
            do_op(tbl[i].wr, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd);
            chk($sformatf("tbl%0d_fault", i), 32'(last_fault), 32'(tbl[i].exp_fault));
            chk($sformatf("tbl%0d_ld", i), last_ld, tbl[i].exp_ld);
        end
        chk("word8_after_bad_sw", mem[8], 32'h00000008);
        chk("word1_wrap", mem[1], 32'hDEADBEEF);

        // Reset landing in the write cycle of an sb must abort the write.
        @(negedge clk);
        op_valid = 1'b1; op_write = 1'b1; op_size = 2'd0; op_unsigned = 1'b0;
        op_addr = 32'h20; op_wdata = 32'h000000CC;
        #1;
        chk("abort_stall", 32'(stall), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_memwrite", 32'(mem_memwrite), 32'h0);
        chk("abort_stall2", 32'(stall), 32'h0);
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0;
        #1;
        chk("abort_idle_memwrite", 32'(mem_memwrite), 32'h0);
        chk("abort_word8", mem[8], 32'h00000008);
        do_op(1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
        chk("abort_lbu", last_ld, 32'h00000008);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        @(negedge clk);
        op_valid = 1'b0;
        for (int i = 0; i < 64; i++) chk($sformatf("final_word%0d", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
